// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART TX scheduler and related UART blocks.
package uart_sched_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam logic [7:0]  OVF_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ECHO = 2'd1,
    MSG  = 2'd2
  } state_e;

  typedef enum logic {
    G_ECHO = 1'b0,
    G_MSG  = 1'b1
  } grant_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == OVF_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head entry is visible combinationally.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX path between an RX echo FIFO and a framed message source,
// with round-robin arbitration, length-limited echo bursts and overflow tracking.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ECHO_BURST = 8
) (
  input  logic                          io_systemClk,
  input  logic                          io_asyncResetn,
  input  logic                          echo_en,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  input  logic                          msg_valid,
  input  logic [7:0]                    msg_data,
  input  logic                          msg_last,
  output logic                          msg_ready,
  output logic                          tx_valid,
  output logic [7:0]                    tx_data,
  input  logic                          tx_ready,
  input  logic                          ovf_clr,
  output logic                          overflow,
  output logic [7:0]                    ovf_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  localparam int unsigned  LW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] LVL_ONE   = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [7:0]   BURST_LAST = 8'(ECHO_BURST - 1);

  state_e      state_q, state_d;
  grant_e      last_grant_q, last_grant_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;
  logic        overflow_q, overflow_d;
  logic [7:0]  ovf_count_q, ovf_count_d;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;
  logic [LW-1:0] fifo_lvl;
  logic          rx_drop;
  logic          pick_echo;

  // full comes from registered pointers, so a same-cycle pop never frees room for a push
  assign fifo_push = rx_valid && echo_en && !fifo_full;
  assign rx_drop   = rx_valid && echo_en && fifo_full;

  uart_sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_echo_fifo (
    .clk     (io_systemClk),
    .rst_n   (io_asyncResetn),
    .push    (fifo_push),
    .wr_data (rx_data),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_lvl)
  );

  assign pick_echo = !fifo_empty && (!msg_valid || (last_grant_q == G_MSG));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    tx_valid     = 1'b0;
    tx_data      = '0;
    msg_ready    = 1'b0;
    fifo_pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_echo) begin
          state_d      = ECHO;
          last_grant_d = G_ECHO;
          burst_cnt_d  = '0;
        end else if (msg_valid) begin
          state_d      = MSG;
          last_grant_d = G_MSG;
          burst_cnt_d  = '0;
        end
      end
      ECHO: begin
        tx_valid = 1'b1;
        tx_data  = fifo_head;
        if (tx_ready) begin
          fifo_pop    = 1'b1;
          burst_cnt_d = burst_cnt_q + 8'd1;
          // FIFO drains to empty only if no push refills it this cycle
          if (((fifo_lvl == LVL_ONE) && !fifo_push) || (burst_cnt_q == BURST_LAST))
            state_d = IDLE;
        end
      end
      MSG: begin
        tx_valid  = msg_valid;
        tx_data   = msg_data;
        msg_ready = tx_ready;
        if (msg_valid && tx_ready && msg_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    overflow_d  = overflow_q;
    ovf_count_d = ovf_count_q;
    if (ovf_clr) begin
      overflow_d  = 1'b0;
      ovf_count_d = '0;
    end else if (rx_drop) begin
      overflow_d  = 1'b1;
      ovf_count_d = sat_inc8(ovf_count_q);
    end
  end

  always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      state_q      <= IDLE;
      last_grant_q <= G_MSG;
      burst_cnt_q  <= '0;
      overflow_q   <= 1'b0;
      ovf_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      overflow_q   <= overflow_d;
      ovf_count_q  <= ovf_count_d;
    end
  end

  assign overflow   = overflow_q;
  assign ovf_count  = ovf_count_q;
  assign fifo_level = fifo_lvl;
  assign busy       = (state_q != IDLE) || !fifo_empty;

endmodule
